// File: rtl/sensor_scan_sched.sv
// Round-robin sensor scan scheduler: one shared range-check datapath serves
// CHANNELS sensor inputs. A sample is captured, checked for range and
// saturation, then presented downstream over a valid/ready handshake.
// Channels that keep producing bad samples are latched faulty and are no
// longer arbitrated until software clears them.
module sensor_scan_sched #(
    parameter int CHANNELS           = 4,
    parameter int SensorGet_LimitBit = 10,
    parameter int BaseUpBound        = 1000,
    parameter int BaseDownBound      = 16,
    parameter int ErrLimit           = 3
) (
    input  logic                                   Clk,
    input  logic                                   Reset,
    input  logic [CHANNELS-1:0]                    ReqValid,
    input  logic [CHANNELS*SensorGet_LimitBit-1:0] ReqData,
    output logic [CHANNELS-1:0]                    ReqAck,
    output logic                                   OutValid,
    input  logic                                   OutReady,
    output logic [$clog2(CHANNELS)-1:0]            OutChannel,
    output logic [SensorGet_LimitBit-1:0]          OutValue,
    output logic [1:0]                             OutError,
    output logic [CHANNELS-1:0]                    ChannelFault,
    input  logic [CHANNELS-1:0]                    FaultClear
);

    localparam int W  = SensorGet_LimitBit;
    localparam int PW = $clog2(CHANNELS);
    localparam int CW = $clog2(ErrLimit + 1);

    // Bounds are held one bit wider than a sample so an upper bound of 2^W
    // still fits and the unsigned compares cannot wrap.
    localparam logic [W:0]    UpLimit     = (W+1)'(BaseUpBound);
    localparam logic [W:0]    DownLimit   = (W+1)'(BaseDownBound);
    localparam logic [W-1:0]  SatValue    = {W{1'b1}};
    localparam logic [CW-1:0] CntLimit    = CW'(ErrLimit);
    localparam logic [PW-1:0] LastChannel = PW'(CHANNELS - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CHECK   = 2'd1;
    localparam logic [1:0] PRESENT = 2'd2;

    logic [1:0]          stateReg;
    logic [1:0]          stateNext;
    logic [PW-1:0]       ptrReg;
    logic [PW-1:0]       winnerReg;
    logic [W-1:0]        sampleReg;
    logic [1:0]          errorReg;
    logic [CHANNELS-1:0] faultVec;

    logic [CHANNELS-1:0] eligible;
    logic [CHANNELS-1:0] candHit;
    logic [PW-1:0]       candIdx [CHANNELS];
    logic [W-1:0]        chanData [CHANNELS];
    logic                grantFound;
    logic [PW-1:0]       grantIdx;

    logic [W:0]          sampleWide;
    logic [1:0]          checkErr;

    // Faulted channels are invisible to the arbiter.
    assign eligible = ReqValid & ~faultVec;

    // Candidate gi is the channel gi places above the pointer, wrapped, so
    // candidate 0 has the highest priority in this round.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : gCand
        logic [PW:0] rawIdx;
        assign rawIdx       = {1'b0, ptrReg} + (PW+1)'(gi);
        assign candIdx[gi]  = (rawIdx >= (PW+1)'(CHANNELS))
                              ? PW'(rawIdx - (PW+1)'(CHANNELS))
                              : rawIdx[PW-1:0];
        assign candHit[gi]  = eligible[candIdx[gi]];
        assign chanData[gi] = ReqData[gi*W +: W];
    end

    // Pick the lowest-numbered hit among the rotated candidates.
    always_comb begin
        grantFound = 1'b0;
        grantIdx   = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (candHit[k]) begin
                grantFound = 1'b1;
                grantIdx   = candIdx[k];
            end
        end
    end

    // Acknowledge the winner only while idle so a sample is taken exactly once.
    always_comb begin
        ReqAck = '0;
        if (!Reset && stateReg == IDLE && grantFound) begin
            ReqAck[grantIdx] = 1'b1;
        end
    end

    // Range and saturation check on the captured sample.
    assign sampleWide  = {1'b0, sampleReg};
    assign checkErr[0] = (sampleWide > UpLimit) || (sampleWide < DownLimit);
    assign checkErr[1] = (sampleReg == SatValue);

    // Next-state logic: capture, check for one cycle, then present until taken.
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:    if (grantFound) stateNext = CHECK;
            CHECK:   stateNext = PRESENT;
            PRESENT: if (OutReady) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // State, pointer and datapath registers; reset discards any sample in flight.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            stateReg  <= IDLE;
            ptrReg    <= '0;
            winnerReg <= '0;
            sampleReg <= '0;
            errorReg  <= '0;
        end else begin
            stateReg <= stateNext;
            case (stateReg)
                IDLE: begin
                    if (grantFound) begin
                        winnerReg <= grantIdx;
                        sampleReg <= chanData[grantIdx];
                    end
                end
                CHECK: begin
                    errorReg <= checkErr;
                end
                PRESENT: begin
                    // The pointer only moves once the result has really been
                    // taken, so the next round starts just after this winner.
                    if (OutReady) begin
                        ptrReg <= (winnerReg == LastChannel) ? '0 : winnerReg + 1'b1;
                    end
                end
                default: begin
                    winnerReg <= winnerReg;
                end
            endcase
        end
    end

    // Per-channel consecutive-error counter and sticky fault flag.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : gChan
        logic [CW-1:0] errCntReg;
        logic [CW-1:0] errCntNext;
        logic          faultReg;
        logic          checkHit;

        assign checkHit = (stateReg == CHECK) && (winnerReg == PW'(gi));

        // Any error bit counts up, saturating at the limit; a clean sample restarts.
        always_comb begin
            errCntNext = '0;
            if (|checkErr) begin
                errCntNext = (errCntReg == CntLimit) ? CntLimit : errCntReg + 1'b1;
            end
        end

        // Software clear takes priority over a same-cycle check update.
        always_ff @(posedge Clk) begin
            if (Reset) begin
                errCntReg <= '0;
                faultReg  <= 1'b0;
            end else if (FaultClear[gi]) begin
                errCntReg <= '0;
                faultReg  <= 1'b0;
            end else if (checkHit) begin
                errCntReg <= errCntNext;
                if (errCntNext == CntLimit) begin
                    faultReg <= 1'b1;
                end
            end
        end

        assign faultVec[gi] = faultReg;
    end

    assign OutValid     = (stateReg == PRESENT);
    assign OutChannel   = winnerReg;
    assign OutValue     = sampleReg;
    assign OutError     = errorReg;
    assign ChannelFault = faultVec;

endmodule

// File: tb/tb_sensor_scan_sched.sv
// Self-checking bench for sensor_scan_sched. Tests queue per-channel samples
// and push the expected results in the order the scheduler should produce
// them; a scoreboard process compares each presented result.
module tb_sensor_scan_sched;

    localparam int CH = 4;
    localparam int W  = 10;

    logic              Clk = 1'b0;
    logic              Reset;
    logic [CH-1:0]     ReqValid;
    logic [CH*W-1:0]   ReqData;
    logic [CH-1:0]     ReqAck;
    logic              OutValid;
    logic              OutReady;
    logic [1:0]        OutChannel;
    logic [W-1:0]      OutValue;
    logic [1:0]        OutError;
    logic [CH-1:0]     ChannelFault;
    logic [CH-1:0]     FaultClear;

    sensor_scan_sched #(
        .CHANNELS(CH), .SensorGet_LimitBit(W), .BaseUpBound(1000),
        .BaseDownBound(16), .ErrLimit(3)
    ) dut (
        .Clk(Clk), .Reset(Reset), .ReqValid(ReqValid), .ReqData(ReqData),
        .ReqAck(ReqAck), .OutValid(OutValid), .OutReady(OutReady),
        .OutChannel(OutChannel), .OutValue(OutValue), .OutError(OutError),
        .ChannelFault(ChannelFault), .FaultClear(FaultClear)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int ch;
        int val;
        int err;
        int fault;
    } exp_t;

    exp_t expQ[$];
    int   ackQ[$];
    int   reqMem[CH][32];
    int   reqHead[CH];
    int   reqTail[CH];
    int   nCompared = 0;
    int   nMismatch = 0;
    int   cycle     = 0;

    // Queue a sample for channel ch; optionally record the expected result.
    task automatic enqueue(input int ch, input int val, input int err,
                           input int fault, input bit expectOut);
        reqMem[ch][reqTail[ch]] = val;
        reqTail[ch]++;
        if (expectOut) expQ.push_back(exp_t'{ch, val, err, fault});
    endtask

    // Requester model: holds data while requesting, advances after an ack.
    task automatic requester_loop();
        logic [CH-1:0] ackS;
        ReqValid = '0;
        ReqData  = '0;
        forever begin
            @(negedge Clk);
            ackS = ReqAck;
            @(posedge Clk);
            #2;
            for (int c = 0; c < CH; c++) begin
                if (ackS[c] && reqHead[c] != reqTail[c]) reqHead[c]++;
                ReqValid[c] = (reqHead[c] != reqTail[c]);
                ReqData[c*W +: W] = (reqHead[c] != reqTail[c]) ? W'(reqMem[c][reqHead[c]]) : '0;
            end
        end
    endtask

    // Scoreboard: legality of acks, latency, and result contents.
    task automatic monitor_loop();
        bit       prevValid = 1'b0;
        int       lat;
        exp_t     e;
        logic [1:0]   expCh;
        logic [W-1:0] expVal;
        logic [1:0]   expErr;
        logic         expFault;
        forever begin
            @(negedge Clk);
            cycle++;
            if (Reset) begin
                ackQ.delete();
                prevValid = 1'b0;
            end else begin
                if (ReqAck != '0) begin
                    nCompared++;
                    if ($countones(ReqAck) != 1 || OutValid) begin
                        nMismatch++;
                        $display("FAIL ack_legal: ReqAck=%b OutValid=%b, required one-hot ack with OutValid=0", ReqAck, OutValid);
                    end
                    nCompared++;
                    if ((ReqAck & ChannelFault) != '0) begin
                        nMismatch++;
                        $display("FAIL ack_faulted: ReqAck=%b ChannelFault=%b, required no ack to faulted channel", ReqAck, ChannelFault);
                    end
                    ackQ.push_back(cycle);
                end
                if (OutValid && !prevValid) begin
                    nCompared++;
                    if (ackQ.size() == 0 || expQ.size() == 0) begin
                        nMismatch++;
                        $display("FAIL unexpected_output: ch=%0d value=%0d, required no output", OutChannel, OutValue);
                    end else begin
                        lat = cycle - ackQ.pop_front();
                        e = expQ[0];
                        expCh = e.ch[1:0];
                        expVal = e.val[W-1:0];
                        expErr = e.err[1:0];
                        expFault = e.fault[0];
                        if (lat != 2) begin
                            nMismatch++;
                            $display("FAIL latency: got %0d cycles, required 2", lat);
                        end
                        nCompared++;
                        if (OutChannel !== expCh) begin
                            nMismatch++;
                            $display("FAIL out_channel: got %0d, required %0d", OutChannel, expCh);
                        end
                        nCompared++;
                        if (OutValue !== expVal) begin
                            nMismatch++;
                            $display("FAIL out_value: got %0d, required %0d", OutValue, expVal);
                        end
                        nCompared++;
                        if (OutError !== expErr) begin
                            nMismatch++;
                            $display("FAIL out_error: ch=%0d value=%0d got %b, required %b", expCh, expVal, OutError, expErr);
                        end
                        nCompared++;
                        if (ChannelFault[expCh] !== expFault) begin
                            nMismatch++;
                            $display("FAIL fault_flag: ch=%0d got %b, required %b", expCh, ChannelFault[expCh], expFault);
                        end
                    end
                end
                if (OutValid && OutReady) begin
                    $display("txn: ch=%0d value=%0d err=%b fault=%b cycle=%0d",
                             OutChannel, OutValue, OutError, ChannelFault, cycle);
                    if (expQ.size() > 0) e = expQ.pop_front();
                end
                prevValid = OutValid;
            end
        end
    endtask

    // Wait until all queued samples have been presented and taken.
    task automatic wait_idle(output bit ok);
        bit empty;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge Clk);
            empty = 1'b1;
            for (int c = 0; c < CH; c++) if (reqHead[c] != reqTail[c]) empty = 1'b0;
            if (empty && expQ.size() == 0 && !OutValid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        nCompared++;
        if (ReqAck !== 4'b0) begin nMismatch++; $display("FAIL reset_ack: got %b, required 0000", ReqAck); end
        nCompared++;
        if (OutValid !== 1'b0) begin nMismatch++; $display("FAIL reset_valid: got %b, required 0", OutValid); end
        nCompared++;
        if (OutChannel !== 2'd0) begin nMismatch++; $display("FAIL reset_channel: got %0d, required 0", OutChannel); end
        nCompared++;
        if (OutValue !== 10'd0) begin nMismatch++; $display("FAIL reset_value: got %0d, required 0", OutValue); end
        nCompared++;
        if (OutError !== 2'b00) begin nMismatch++; $display("FAIL reset_error: got %b, required 00", OutError); end
        nCompared++;
        if (ChannelFault !== 4'b0) begin nMismatch++; $display("FAIL reset_fault: got %b, required 0000", ChannelFault); end
        @(posedge Clk);
        #2;
        Reset = 1'b0;
    endtask

    task automatic test_round_robin();
        bit ok;
        for (int c = 0; c < CH; c++) enqueue(c, (c + 1) * 100, 0, 0, 1'b1);
        wait_idle(ok);
        nCompared++;
        if (!ok) begin nMismatch++; $display("FAIL rr_drain: got timeout, required all 4 results"); end
    endtask

    task automatic test_range();
        bit ok;
        enqueue(2, 1000, 0, 0, 1'b1);
        enqueue(2, 1001, 1, 0, 1'b1);
        enqueue(2, 15,   1, 0, 1'b1);
        enqueue(2, 16,   0, 0, 1'b1);
        wait_idle(ok);
        nCompared++;
        if (!ok) begin nMismatch++; $display("FAIL range_drain: got timeout, required 4 results"); end
    endtask

    task automatic test_saturate();
        bit ok;
        enqueue(1, 1023, 3, 0, 1'b1);
        wait_idle(ok);
        nCompared++;
        if (!ok) begin nMismatch++; $display("FAIL sat_drain: got timeout, required 1 result"); end
    endtask

    task automatic test_fault();
        bit ok;
        for (int i = 0; i < 3; i++) enqueue(3, 1020, 1, (i == 2) ? 1 : 0, 1'b1);
        wait_idle(ok);
        nCompared++;
        if (!ok) begin nMismatch++; $display("FAIL fault_drain: got timeout, required 3 results"); end
        nCompared++;
        if (ChannelFault !== 4'b1000) begin nMismatch++; $display("FAIL fault_latched: got %b, required 1000", ChannelFault); end
        enqueue(3, 500, 0, 0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            @(negedge Clk);
            nCompared++;
            if (ReqAck !== 4'b0) begin nMismatch++; $display("FAIL fault_blocks_ack: got %b, required 0000", ReqAck); end
        end
        @(posedge Clk); #2;
        FaultClear = 4'b1000;
        @(posedge Clk); #2;
        FaultClear = 4'b0000;
        @(negedge Clk);
        nCompared++;
        if (ChannelFault !== 4'b0000) begin nMismatch++; $display("FAIL fault_clear: got %b, required 0000", ChannelFault); end
        // Two errors after the clear must not re-fault if the counter restarted.
        enqueue(3, 1020, 1, 0, 1'b1);
        enqueue(3, 1020, 1, 0, 1'b1);
        enqueue(3, 100,  0, 0, 1'b1);
        wait_idle(ok);
        nCompared++;
        if (!ok) begin nMismatch++; $display("FAIL clear_drain: got timeout, required 4 results"); end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit found;
        @(posedge Clk); #2;
        OutReady = 1'b0;
        enqueue(0, 111, 0, 0, 1'b1);
        enqueue(1, 222, 0, 0, 1'b1);
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge Clk);
            if (OutValid) begin found = 1'b1; break; end
        end
        nCompared++;
        if (!found) begin nMismatch++; $display("FAIL bp_valid: got no OutValid, required OutValid within 20 cycles"); end
        for (int k = 0; k < 5; k++) begin
            @(negedge Clk);
            nCompared++;
            if (OutValid !== 1'b1 || OutChannel !== 2'd0 || OutValue !== 10'd111 || OutError !== 2'b00) begin
                nMismatch++;
                $display("FAIL bp_hold: got v=%b ch=%0d val=%0d err=%b, required v=1 ch=0 val=111 err=00",
                         OutValid, OutChannel, OutValue, OutError);
            end
            nCompared++;
            if (ReqAck !== 4'b0) begin nMismatch++; $display("FAIL bp_no_ack: got %b, required 0000", ReqAck); end
        end
        @(posedge Clk); #2;
        OutReady = 1'b1;
        wait_idle(ok);
        nCompared++;
        if (!ok) begin nMismatch++; $display("FAIL bp_drain: got timeout, required 2 results"); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit found;
        enqueue(2, 333, 0, 0, 1'b0);
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge Clk);
            if (ReqAck[2]) begin found = 1'b1; break; end
        end
        nCompared++;
        if (!found) begin nMismatch++; $display("FAIL rm_ack: got no ReqAck[2], required ack within 20 cycles"); end
        @(posedge Clk); #2;
        Reset = 1'b1;
        @(posedge Clk); #2;
        @(negedge Clk);
        nCompared++;
        if (OutValid !== 1'b0 || OutChannel !== 2'd0 || OutValue !== 10'd0 || OutError !== 2'b00 || ReqAck !== 4'b0) begin
            nMismatch++;
            $display("FAIL rm_outputs: got v=%b ch=%0d val=%0d err=%b ack=%b, required all 0",
                     OutValid, OutChannel, OutValue, OutError, ReqAck);
        end
        @(posedge Clk); #2;
        Reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            nCompared++;
            if (OutValid !== 1'b0) begin nMismatch++; $display("FAIL rm_discard: got OutValid=%b, required 0", OutValid); end
        end
        // Pointer must restart at 0, so channel 1 wins over channel 3.
        enqueue(1, 444, 0, 0, 1'b1);
        enqueue(3, 555, 0, 0, 1'b1);
        wait_idle(ok);
        nCompared++;
        if (!ok) begin nMismatch++; $display("FAIL rm_drain: got timeout, required 2 results"); end
    endtask

    // Main sequence: background requester and scoreboard, then the tests.
    initial begin
        Reset      = 1'b1;
        OutReady   = 1'b1;
        FaultClear = '0;
        for (int c = 0; c < CH; c++) begin
            reqHead[c] = 0;
            reqTail[c] = 0;
        end
        fork
            requester_loop();
            monitor_loop();
        join_none
        test_reset();
        test_round_robin();
        test_range();
        test_saturate();
        test_fault();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

    // Hard stop in case something stalls outside the bounded waits.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 time units");
        $fatal(1);
    end

endmodule

// File: doc/sensor_scan_sched.md
# sensor_scan_sched

Round-robin scheduler that shares one sensor range-check datapath among `CHANNELS` sensor inputs in the fuzzy controller front end. It accepts one sample at a time from the requesting channels, bounds-checks the sample, and presents the fixed value, error code and channel id downstream with a valid/ready handshake. It also tracks consecutive errors per channel and latches a per-channel fault that removes the channel from arbitration until software clears it.

## Interface
- `CHANNELS`, 4: number of sensor channels, 2..16.
- `SensorGet_LimitBit`, 10: sample width W.
- `BaseUpBound`, 1000: largest in-range sample value.
- `BaseDownBound`, 16: smallest in-range sample value.
- `ErrLimit`, 3: consecutive erroneous samples that set a channel fault, 1..15.

Ports:
- `Clk`, in, 1: single clock; all state changes on the rising edge.
- `Reset`, in, 1: synchronous, active-high.
- `ReqValid`, in, CHANNELS: per-channel sample request.
- `ReqData`, in, CHANNELS*W: channel i sample at bits [i*W +: W].
- `ReqAck`, out, CHANNELS: one-hot; high for the one cycle in which the channel's sample is captured.
- `OutValid`, out, 1: result available.
- `OutReady`, in, 1: downstream accepts the result.
- `OutChannel`, out, $clog2(CHANNELS): channel id of the result.
- `OutValue`, out, W: captured sample.
- `OutError`, out, 2: [0] = out of range, [1] = saturated (sample is all ones).
- `ChannelFault`, out, CHANNELS: sticky per-channel fault.
- `FaultClear`, in, CHANNELS: per-channel fault and counter clear.

## Operation
- FSM states are IDLE, CHECK and PRESENT.
- **IDLE:** eligible channels are `ReqValid & ~ChannelFault`.
  - If any channel is eligible, pick the first one searching upward from the round-robin pointer `Ptr`, wrapping at CHANNELS-1 to 0.
  - `ReqAck[winner]` is driven combinationally high in this cycle.
  - On the edge, capture the sample and channel id, then go to CHECK.
  - If no channel is eligible, stay in IDLE with `ReqAck` = 0.
- **CHECK:** one cycle, register the check results.
  - `OutError[0]` = (sample > `BaseUpBound`) or (sample < `BaseDownBound`), using unsigned compare.
  - `OutError[1]` = (sample == 2^W-1).
  - Update the winner's error counter: any error bit set increments it, saturating at `ErrLimit`; a clean sample zeroes it.
  - When the counter reaches `ErrLimit`, set `ChannelFault[winner]`.
  - Go to PRESENT.
- **PRESENT:** `OutValid` = 1, and `OutChannel`, `OutValue` and `OutError` are held stable.
  - On `OutValid && OutReady`, go to IDLE and set `Ptr` = winner+1, wrapping.
  - Otherwise hold indefinitely; no new sample is accepted.
- **Requester rules:** hold `ReqData` stable while `ReqValid` is high; drop or renew the request after `ReqAck`. A channel that keeps `ReqValid` high is re-arbitrated on the next IDLE visit.
- **FaultClear:** `FaultClear[i]` zeroes counter i and `ChannelFault[i]` on the next edge. If it coincides with a CHECK update for channel i, the clear wins.
- A fault set during CHECK does not retract the result being presented.
- Arithmetic:
  - Compares are W+1 bits wide, so `BaseUpBound` = 2^W does not overflow.
  - Counters are $clog2(ErrLimit+1) bits wide.

## Timing
- **Reset values:**
  - State = IDLE, `Ptr` = 0.
  - `ReqAck`, `OutValid`, `OutChannel`, `OutValue` and `OutError` = 0.
  - `ChannelFault` = 0 and all counters = 0.
- **Reset mid-operation:** a captured or presented sample is discarded with no output.
- **Latency:** `ReqAck` in cycle t, then `OutValid` rises in cycle t+2.
- **Throughput:** the earliest next `ReqAck` is the cycle after the handshake completes, so one sample per 3 cycles when `OutReady` = 1.
- `ChannelFault` changes in the same edge that enters PRESENT, so it is visible in the first `OutValid` cycle.
- `ReqAck` is never high outside IDLE and is never high for a faulted channel.
- **Boundaries:**
  - Sample == `BaseUpBound` or == `BaseDownBound` is in range.
  - With all channels requesting, grants go in strict rotation.
  - With a single requester, it is granted every visit regardless of `Ptr`.

## Test plan
- Reset, then channels 0..3 all request with values 100, 200, 300, 400 and `OutReady` = 1 → grants in order 0,1,2,3; each `OutValid` 2 cycles after its `ReqAck`; `OutError` = 0.
- Ch2 requests 1000, then 1001, then 15, then 16 (`BaseUpBound` 1000, `BaseDownBound` 16) → `OutError[0]` = 0, 1, 1, 0.
- Ch1 requests 1023 → `OutError` = 2'b11.
- Ch3 sends three consecutive samples of 1020 → `ChannelFault[3]` rises with the 3rd `OutValid`; a later ch3 `ReqValid` gets no `ReqAck`. Pulse `FaultClear[3]` → ch3 is granted again with counter 0.
- Hold `OutReady` = 0 for 5 cycles in PRESENT while ch0 and ch1 request → outputs stable, no `ReqAck`. Release → next grant goes to the channel after the presented one.
- Assert `Reset` one cycle after a `ReqAck` → no `OutValid`; all outputs 0; the next grant starts from channel 0.
